// File: rtl/verdict_pkg.sv
// Shared types for verdict_tally.
//   state_e   : report FSM states, one report word per R_* state
//   rpt_tag_e : tag carried with each report word
package verdict_pkg;

   typedef enum logic [2:0] {
      COLLECT,
      R_TOTAL,
      R_PASS,
      R_FAIL,
      R_FFAIL
   } state_e;

   typedef enum logic [1:0] {
      TAG_TOTAL,
      TAG_PASS,
      TAG_FAIL,
      TAG_FFAIL
   } rpt_tag_e;

endpackage

// File: rtl/verdict_tally_if.sv
// Verdict input link, report output link and status of verdict_tally.
//   res_valid/res_ready/res_pass/res_id : verdict stream (producer -> tally)
//   fin_req                             : report request level
//   rpt_valid/rpt_ready/rpt_tag/
//   rpt_data/rpt_last                   : report word stream (tally -> sink)
//   busy, sat                           : status
// slave = the tally itself, master = producer/sink side.
interface verdict_tally_if #(
   parameter int CNT_W = 8,
   parameter int ID_W  = 4
);
   logic             res_valid;
   logic             res_ready;
   logic             res_pass;
   logic [ID_W-1:0]  res_id;
   logic             fin_req;
   logic             rpt_valid;
   logic             rpt_ready;
   logic [1:0]       rpt_tag;
   logic [CNT_W-1:0] rpt_data;
   logic             rpt_last;
   logic             busy;
   logic             sat;

   modport slave (
      input  res_valid, res_pass, res_id, fin_req, rpt_ready,
      output res_ready, rpt_valid, rpt_tag, rpt_data, rpt_last, busy, sat
   );

   modport master (
      output res_valid, res_pass, res_id, fin_req, rpt_ready,
      input  res_ready, rpt_valid, rpt_tag, rpt_data, rpt_last, busy, sat
   );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : count up by one unless already at max
//   cnt        : current count
//   at_max     : cnt == 2^W-1
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic         at_max
);

   assign at_max = &cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && !at_max)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/verdict_tally.sv
// Verdict tally: counts pass/fail verdicts and, on fin_req, emits a four-word
// report (TOTAL, PASS, FAIL, FIRST_FAIL) over a valid/ready link, then clears.
//   clk   : rising-edge clock
//   rst_n : async active-low reset
//   bus   : verdict_tally_if slave (verdict input, report output, busy/sat)
// ID_W must be smaller than CNT_W so the has_fail flag and the id do not overlap
// in the FIRST_FAIL word.
module verdict_tally
   import verdict_pkg::*;
#(
   parameter int CNT_W = 8,
   parameter int ID_W  = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   verdict_tally_if.slave  bus
);

   state_e           state, state_nxt;
   logic             collect;
   logic             hs;
   logic             clr;
   logic [CNT_W-1:0] total_cnt, pass_cnt, fail_cnt;
   logic             total_max, pass_max, fail_max;
   logic             has_fail;
   logic [ID_W-1:0]  first_id;
   rpt_tag_e         tag;
   logic [CNT_W-1:0] data;
   logic [CNT_W-1:0] ffail_word;

   assign collect = (state == COLLECT);
   assign hs      = bus.res_valid & collect;
   // Everything clears when the last report word is taken.
   assign clr     = (state == R_FFAIL) & bus.rpt_ready;

   sat_counter #(.W(CNT_W)) u_total (
      .clk(clk), .rst_n(rst_n), .clr(clr), .inc(hs),
      .cnt(total_cnt), .at_max(total_max)
   );
   sat_counter #(.W(CNT_W)) u_pass (
      .clk(clk), .rst_n(rst_n), .clr(clr), .inc(hs & bus.res_pass),
      .cnt(pass_cnt), .at_max(pass_max)
   );
   sat_counter #(.W(CNT_W)) u_fail (
      .clk(clk), .rst_n(rst_n), .clr(clr), .inc(hs & ~bus.res_pass),
      .cnt(fail_cnt), .at_max(fail_max)
   );

   // A counter at max holds there until the report clears it, so the OR of the
   // at_max flags already behaves as a sticky flag cleared with the counters.
   assign bus.sat = total_max | pass_max | fail_max;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         has_fail <= 1'b0;
         first_id <= '0;
      end else if (clr) begin
         has_fail <= 1'b0;
         first_id <= '0;
      end else if (hs && !bus.res_pass && !has_fail) begin
         has_fail <= 1'b1;
         first_id <= bus.res_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= COLLECT;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         COLLECT: if (bus.fin_req)   state_nxt = R_TOTAL;
         R_TOTAL: if (bus.rpt_ready) state_nxt = R_PASS;
         R_PASS:  if (bus.rpt_ready) state_nxt = R_FAIL;
         R_FAIL:  if (bus.rpt_ready) state_nxt = R_FFAIL;
         R_FFAIL: if (bus.rpt_ready) state_nxt = COLLECT;
         default:                    state_nxt = COLLECT;
      endcase
   end

   always_comb begin
      ffail_word              = '0;
      ffail_word[CNT_W-1]     = has_fail;
      ffail_word[ID_W-1:0]    = first_id;
   end

   // Report outputs decode from state only; counters cannot move outside
   // COLLECT, so the word holds stable while the sink stalls.
   always_comb begin
      tag  = TAG_TOTAL;
      data = '0;
      case (state)
         R_TOTAL: begin tag = TAG_TOTAL; data = total_cnt;  end
         R_PASS:  begin tag = TAG_PASS;  data = pass_cnt;   end
         R_FAIL:  begin tag = TAG_FAIL;  data = fail_cnt;   end
         R_FFAIL: begin tag = TAG_FFAIL; data = ffail_word; end
         default: begin tag = TAG_TOTAL; data = '0;         end
      endcase
   end

   assign bus.res_ready = collect;
   assign bus.busy      = ~collect;
   assign bus.rpt_valid = ~collect;
   assign bus.rpt_tag   = tag;
   assign bus.rpt_data  = data;
   assign bus.rpt_last  = (state == R_FFAIL);

endmodule
